count_seq_decoder_fsm: RTL and testbench
========================================

COUNT_SEQ_DECODER_FSM -- requirements
Module: count_seq_decoder_fsm

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-low (rst=0 resets on the next rising clk).
REQ-003 SHALL have port: valid  input  1  count_in is a sample this cycle.
REQ-004 SHALL have port: count_in  input  3  3-bit counter value being observed.
REQ-005 SHALL have port: dir  output  1  decoded direction: 1=up, 0=down; registered.
REQ-006 SHALL have port: locked  output  1  high while in S_UP or S_DOWN; registered.
REQ-007 SHALL have port: wrap  output  1  one-cycle pulse on a legal 7->0 (up) or 0->7 (down) step.
REQ-008 SHALL have port: dir_chg  output  1  one-cycle pulse on a legal direction reversal while locked.
REQ-009 SHALL have port: err  output  1  one-cycle pulse on an illegal step.
REQ-010 SHALL have port: err_cnt  output  8  count of err pulses since reset; saturates at 255.

Function
REQ-011 SHALL implement FSM states S_IDLE, S_ACQ, S_UP, S_DOWN; only valid=1 cycles evaluate a sample; valid=0 holds state, prev, dir and err_cnt, and drives wrap/dir_chg/err to 0.
REQ-012 SHALL hold an internal 3-bit prev register holding the last accepted sample.
REQ-013 SHALL compute step tests modulo 8: up = (count_in == prev+1 mod 8), down = (count_in == prev-1 mod 8).
REQ-014 SHALL, in S_IDLE with valid: load prev=count_in, go S_ACQ, no pulses.
REQ-015 SHALL, in S_ACQ with valid: up -> S_UP, dir=1; down -> S_DOWN, dir=0; otherwise err pulse, stay S_ACQ; prev=count_in in all cases.
REQ-016 SHALL, in S_UP with valid: up -> stay, wrap=1 if prev==7; down -> S_DOWN, dir=0, dir_chg=1; otherwise err=1, go S_ACQ; prev=count_in.
REQ-017 SHALL, in S_DOWN with valid: down -> stay, wrap=1 if prev==0; up -> S_UP, dir=1, dir_chg=1; otherwise err=1, go S_ACQ; prev=count_in.
REQ-018 SHALL treat count_in==prev (hold) per REQ-026/REQ-027; hold never sets wrap or dir_chg.
REQ-019 SHALL register all outputs; a sample on valid at edge N affects outputs visible after edge N (one-cycle latency).
REQ-020 SHALL assert wrap and dir_chg together on a reversal step only if the step also crosses 7/0 (e.g. S_DOWN, prev=7, count_in=0 gives dir_chg=1, wrap=1).
REQ-021 SHALL increment err_cnt by 1 on each err pulse, saturating at 255 (no wrap to 0).

Reset
REQ-022 SHALL, while rst=0 at a rising edge, set state=S_IDLE, prev=0, dir=0, locked=0, wrap=0, dir_chg=0, err=0, err_cnt=0.
REQ-023 SHALL give reset priority over valid; a sample presented during reset is discarded.
REQ-024 SHALL, on reset mid-lock, lose lock; the first sample after release is only captured (S_IDLE->S_ACQ), never flagged as err.
REQ-025 SHALL leave outputs at reset values until the second valid sample after reset release.

Configuration
REQ-026 SHALL, with macro COUNT_HOLD_ALLOW_EN defined, treat count_in==prev as legal: no state change, no pulses, locked unchanged.
REQ-027 SHALL, without COUNT_HOLD_ALLOW_EN, treat count_in==prev as an illegal step (err=1, err_cnt+1, S_UP/S_DOWN -> S_ACQ, S_ACQ stays).

Verification
REQ-028 SHALL cover: rst=0 two cycles, then valid samples 0,1,2,...,7,0,1 -> locked=1 after sample 1, dir=1, wrap=1 exactly one cycle after the 7->0 sample, err=0 throughout.
REQ-029 SHALL cover: locked up at 3, then samples 2,1,0,7 -> dir_chg=1 once (3->2), dir=0, wrap=1 once (0->7), err_cnt=0.
REQ-030 SHALL cover: locked up at 2, sample 5 -> err=1 one cycle, locked=0, err_cnt=1; then 6 -> locked=1, dir=1.
REQ-031 SHALL cover: repeated sample 4,4 while locked -> with COUNT_HOLD_ALLOW_EN no err and locked=1; without it err=1 and locked=0.
REQ-032 SHALL cover: 300 consecutive illegal samples (alternating 0,4) -> err_cnt saturates at 255; then rst=0 for one cycle mid-stream -> all outputs 0, state S_IDLE.
REQ-033 SHALL cover: valid=0 gaps between legal up samples -> no pulses during gaps, lock and dir held, sequence continues without err.

Source files
------------

// File: rtl/count_seq_decoder_fsm_if.sv
// Sample bus into the counter-sequence decoder and its decoded status back out.
// Latency: none, this is just wiring.
// Backpressure: none; the decoder accepts a sample on every valid cycle.
interface count_seq_decoder_fsm_if;
  logic       valid;
  logic [2:0] count_in;
  logic       dir;
  logic       locked;
  logic       wrap;
  logic       dir_chg;
  logic       err;
  logic [7:0] err_cnt;

  // Producer of samples and consumer of the decoded status
  modport master (
    output valid, count_in,
    input  dir, locked, wrap, dir_chg, err, err_cnt
  );

  // The decoder itself
  modport slave (
    input  valid, count_in,
    output dir, locked, wrap, dir_chg, err, err_cnt
  );
endinterface

// File: rtl/count_seq_decoder_fsm.sv
// Tracks a 3-bit counter, decodes up/down direction, flags wraps, reversals and illegal steps.
// Latency: one cycle; a sample on valid at edge N shows on the registered outputs after edge N.
// Backpressure: none; every valid cycle is evaluated. Build option COUNT_HOLD_ALLOW_EN makes a repeated value legal.
module count_seq_decoder_fsm (
  input  logic                    clk,
  input  logic                    rst,
  count_seq_decoder_fsm_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_UP   = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] prev, prev_nxt;
  logic       dir_q, dir_nxt;
  logic       locked_q, locked_nxt;
  logic       wrap_q, wrap_nxt;
  logic       dir_chg_q, dir_chg_nxt;
  logic       err_q, err_nxt;
  logic [7:0] err_cnt_q, err_cnt_nxt;

  logic [2:0] prev_inc;
  logic [2:0] prev_dec;
  logic       step_up;
  logic       step_dn;
  logic       hold_ok;
  logic       illegal;

  // Neighbour values wrap naturally in 3 bits, giving the modulo-8 step tests.
  assign prev_inc = prev + 3'd1;
  assign prev_dec = prev - 3'd1;
  assign step_up  = (bus.count_in == prev_inc);
  assign step_dn  = (bus.count_in == prev_dec);
`ifdef COUNT_HOLD_ALLOW_EN
  assign hold_ok  = (bus.count_in == prev);
`else
  assign hold_ok  = 1'b0;
`endif
  assign illegal  = !step_up && !step_dn && !hold_ok;

  // State register; reset wins over any sample presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decision; only valid cycles move the machine, an allowed hold falls through as "stay".
  always_comb begin
    state_nxt = state;
    if (bus.valid) begin
      case (state)
        S_IDLE: state_nxt = S_ACQ;
        S_ACQ: begin
          if (step_up)      state_nxt = S_UP;
          else if (step_dn) state_nxt = S_DOWN;
        end
        S_UP: begin
          if (step_dn)      state_nxt = S_DOWN;
          else if (illegal) state_nxt = S_ACQ;
        end
        S_DOWN: begin
          if (step_up)      state_nxt = S_UP;
          else if (illegal) state_nxt = S_ACQ;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode; pulses default low so a valid=0 cycle clears them while dir/prev/err_cnt hold.
  always_comb begin
    prev_nxt    = prev;
    dir_nxt     = dir_q;
    wrap_nxt    = 1'b0;
    dir_chg_nxt = 1'b0;
    err_nxt     = 1'b0;
    if (bus.valid) begin
      prev_nxt = bus.count_in;
      case (state)
        S_ACQ: begin
          if (step_up)      dir_nxt = 1'b1;
          else if (step_dn) dir_nxt = 1'b0;
          else if (illegal) err_nxt = 1'b1;
        end
        S_UP: begin
          if (step_up) begin
            wrap_nxt = (prev == 3'd7);
          end else if (step_dn) begin
            dir_nxt     = 1'b0;
            dir_chg_nxt = 1'b1;
            wrap_nxt    = (prev == 3'd0);
          end else if (illegal) begin
            err_nxt = 1'b1;
          end
        end
        S_DOWN: begin
          if (step_dn) begin
            wrap_nxt = (prev == 3'd0);
          end else if (step_up) begin
            dir_nxt     = 1'b1;
            dir_chg_nxt = 1'b1;
            wrap_nxt    = (prev == 3'd7);
          end else if (illegal) begin
            err_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // Error count sticks at 255 rather than rolling over.
    err_cnt_nxt = err_cnt_q;
    if (err_nxt && (err_cnt_q != 8'hFF)) err_cnt_nxt = err_cnt_q + 8'd1;
    locked_nxt = (state_nxt == S_UP) || (state_nxt == S_DOWN);
  end

  // Output and sample registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev      <= 3'd0;
      dir_q     <= 1'b0;
      locked_q  <= 1'b0;
      wrap_q    <= 1'b0;
      dir_chg_q <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      prev      <= prev_nxt;
      dir_q     <= dir_nxt;
      locked_q  <= locked_nxt;
      wrap_q    <= wrap_nxt;
      dir_chg_q <= dir_chg_nxt;
      err_q     <= err_nxt;
      err_cnt_q <= err_cnt_nxt;
    end
  end

  assign bus.dir     = dir_q;
  assign bus.locked  = locked_q;
  assign bus.wrap    = wrap_q;
  assign bus.dir_chg = dir_chg_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_count_seq_decoder_fsm.sv
// Testbench for count_seq_decoder_fsm: directed scenarios then randomized samples against a step-rule model.
// Latency: expects outputs one cycle after each sampled edge.
// Backpressure: none exercised; valid gaps are inserted to check holding behaviour.
module tb_count_seq_decoder_fsm;

`ifdef COUNT_HOLD_ALLOW_EN
  localparam bit HOLD_OK = 1'b1;
`else
  localparam bit HOLD_OK = 1'b0;
`endif

  logic clk;
  logic rst;

  count_seq_decoder_fsm_if ifc ();

  count_seq_decoder_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: "seen a first sample", "locked", direction, last sample, error count.
  int m_have, m_locked, m_dir, m_prev, m_cnt;
  int e_wrap, e_dchg, e_err;
  // Pulse tallies for scenario-level checks
  int sc_wrap, sc_dchg, sc_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_locked = 0; m_dir = 0; m_prev = 0; m_cnt = 0;
    e_wrap = 0; e_dchg = 0; e_err = 0;
  endtask

  // Apply one accepted sample using the distance (c - prev) mod 8.
  task automatic model_sample(input int c);
    int d;
    int nd;
    e_wrap = 0; e_dchg = 0; e_err = 0;
    if (m_have == 0) begin
      m_have = 1;
      m_prev = c;
      return;
    end
    d = (c - m_prev + 8) % 8;
    if (d == 1 || d == 7) begin
      nd = (d == 1) ? 1 : 0;
      if (m_locked != 0) begin
        e_dchg = (nd != m_dir) ? 1 : 0;
        e_wrap = ((d == 1 && m_prev == 7) || (d == 7 && m_prev == 0)) ? 1 : 0;
      end
      m_locked = 1;
      m_dir    = nd;
    end else if (d == 0 && HOLD_OK) begin
      // a repeated value is simply accepted
    end else begin
      e_err    = 1;
      m_locked = 0;
      if (m_cnt < 255) m_cnt++;
    end
    m_prev = c;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dir"},     ifc.dir,     m_dir);
    check({tag, ".locked"},  ifc.locked,  m_locked);
    check({tag, ".wrap"},    ifc.wrap,    e_wrap);
    check({tag, ".dir_chg"}, ifc.dir_chg, e_dchg);
    check({tag, ".err"},     ifc.err,     e_err);
    check({tag, ".err_cnt"}, ifc.err_cnt, m_cnt);
  endtask

  // One clock: drive on the falling edge, update model at the rising edge, check just after it.
  task automatic cyc(input string tag, input bit r, input bit v, input int c);
    logic [31:0] cv;
    cv = c;
    @(negedge clk);
    rst          = r;
    ifc.valid    = v;
    ifc.count_in = cv[2:0];
    @(posedge clk);
    e_wrap = 0; e_dchg = 0; e_err = 0;
    if (!r) model_reset();
    else if (v) model_sample(c);
    #1;
    check_all(tag);
    sc_wrap += int'(ifc.wrap);
    sc_dchg += int'(ifc.dir_chg);
    sc_err  += int'(ifc.err);
  endtask

  task automatic clr_tally();
    sc_wrap = 0; sc_dchg = 0; sc_err = 0;
  endtask

  initial begin
    int k, c, gap;
    n_vec = 0; n_err = 0;
    rst = 1'b0; ifc.valid = 1'b0; ifc.count_in = 3'd0;
    model_reset();
    clr_tally();

    // Reset for two cycles, the second with a sample that must be discarded
    cyc("rst0", 0, 0, 0);
    cyc("rst1", 0, 1, 5);

    // Count up 0..7,0,1: lock after sample 1, one wrap, no errors
    clr_tally();
    for (int i = 0; i < 10; i++) begin
      cyc("up_seq", 1, 1, i % 8);
      if (i == 0) check("up_seq.first_capture_unlocked", ifc.locked, 0);
      if (i == 1) check("up_seq.locked_after_1", ifc.locked, 1);
    end
    check("up_seq.wraps", sc_wrap, 1);
    check("up_seq.errs", sc_err, 0);
    check("up_seq.dir", ifc.dir, 1);

    // Locked up at 3, then 2,1,0,7: one reversal, one 0->7 wrap
    cyc("rst_b", 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("rev_pre", 1, 1, i);
    clr_tally();
    cyc("rev", 1, 1, 2);
    check("rev.dir_chg_first", ifc.dir_chg, 1);
    cyc("rev", 1, 1, 1);
    cyc("rev", 1, 1, 0);
    cyc("rev", 1, 1, 7);
    check("rev.wrap_last", ifc.wrap, 1);
    check("rev.dchg_total", sc_dchg, 1);
    check("rev.wrap_total", sc_wrap, 1);
    check("rev.dir", ifc.dir, 0);
    check("rev.err_cnt", ifc.err_cnt, 0);

    // Reversal that also crosses 7/0: locked down at 7 then 0
    cyc("rst_w", 0, 0, 0);
    cyc("dw", 1, 1, 1);
    cyc("dw", 1, 1, 0);
    cyc("dw", 1, 1, 7);
    cyc("dw", 1, 1, 0);
    check("dw.dir_chg", ifc.dir_chg, 1);
    check("dw.wrap", ifc.wrap, 1);

    // Locked up at 2, jump to 5 is illegal, then 6 relocks upward
    cyc("rst_c", 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("jump_pre", 1, 1, i);
    cyc("jump", 1, 1, 5);
    check("jump.err", ifc.err, 1);
    check("jump.locked", ifc.locked, 0);
    check("jump.err_cnt", ifc.err_cnt, 1);
    cyc("jump_relock", 1, 1, 6);
    check("jump.relock", ifc.locked, 1);
    check("jump.redir", ifc.dir, 1);
    check("jump.err_clear", ifc.err, 0);

    // Repeated 4 while locked
    cyc("rst_d", 0, 0, 0);
    cyc("hold_pre", 1, 1, 3);
    cyc("hold_pre", 1, 1, 4);
    cyc("hold", 1, 1, 4);
`ifdef COUNT_HOLD_ALLOW_EN
    check("hold.err", ifc.err, 0);
    check("hold.locked", ifc.locked, 1);
`else
    check("hold.err", ifc.err, 1);
    check("hold.locked", ifc.locked, 0);
`endif

    // Legal up samples with valid=0 gaps between them
    cyc("rst_e", 0, 0, 0);
    clr_tally();
    for (int i = 0; i < 12; i++) begin
      cyc("gap_s", 1, 1, i % 8);
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        cyc("gap_idle", 1, 0, $urandom_range(0, 7));
        check("gap_idle.no_wrap", ifc.wrap, 0);
      end
    end
    check("gap.errs", sc_err, 0);
    check("gap.locked", ifc.locked, 1);
    check("gap.dir", ifc.dir, 1);

    // 300 alternating illegal samples saturate the error count, then a one-cycle reset
    cyc("rst_f", 0, 0, 0);
    for (int i = 0; i < 300; i++) cyc("sat", 1, 1, (i % 2 == 1) ? 4 : 0);
    check("sat.err_cnt", ifc.err_cnt, 255);
    check("sat.err_pulse", ifc.err, 1);
    cyc("sat_rst", 0, 1, 0);
    check("sat_rst.err_cnt", ifc.err_cnt, 0);
    check("sat_rst.locked", ifc.locked, 0);
    // After release the first sample is only captured, never an error
    cyc("sat_post", 1, 1, 4);
    check("sat_post.err", ifc.err, 0);
    cyc("sat_post", 1, 1, 0);

    // Randomized traffic biased toward legal steps, with occasional resets and gaps
    for (int i = 0; i < 2000; i++) begin
      k = $urandom_range(0, 9);
      if (k < 4)      c = (m_prev + 1) % 8;
      else if (k < 7) c = (m_prev + 7) % 8;
      else if (k < 8) c = m_prev;
      else            c = $urandom_range(0, 7);
      cyc("rand", ($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
